neopixel_frame_sched: RTL and testbench



---
 rtl/neopixel_frame_sched_if.sv | 23 ++
 rtl/neopixel_frame_sched.sv | 181 ++++++++++++++++++
 tb/tb_neopixel_frame_sched.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/neopixel_frame_sched_if.sv
// CSR-side and NEOPIXEL-side bus bundle of the frame scheduler; slave is the scheduler's view.
interface neopixel_frame_sched_if;
  logic [2:0]  iCSR_ADDRESS;
  logic        iCSR_READ;
  logic [31:0] oCSR_READ_DATA;
  logic        iCSR_WRITE;
  logic [31:0] iCSR_WRITE_DATA;
  logic [3:0]  oNP_ADDRESS;
  logic        oNP_WRITE;
  logic [31:0] oNP_WRITE_DATA;
  logic        iNP_IRQ;
  logic        oIRQ;

  modport slave (
    input  iCSR_ADDRESS, iCSR_READ, iCSR_WRITE, iCSR_WRITE_DATA, iNP_IRQ,
    output oCSR_READ_DATA, oNP_ADDRESS, oNP_WRITE, oNP_WRITE_DATA, oIRQ
  );

  modport master (
    output iCSR_ADDRESS, iCSR_READ, iCSR_WRITE, iCSR_WRITE_DATA, iNP_IRQ,
    input  oCSR_READ_DATA, oNP_ADDRESS, oNP_WRITE, oNP_WRITE_DATA, oIRQ
  );
endinterface

// File: rtl/neopixel_frame_sched.sv
// Periodic double-buffered NEOPIXEL frame scheduler; tick-to-first-NEOPIXEL-write latency 1 clock.
// No backpressure: NEOPIXEL writes are single-cycle with no wait, CSR reads return on the next clock.
module neopixel_frame_sched #(
  parameter logic [31:0] pTIMEOUT    = 32'd50_000_000,
  parameter logic [31:0] pPERIOD_RST = 32'd1_666_666
) (
  input logic                   iCLOCK,
  input logic                   iRESET,
  neopixel_frame_sched_if.slave bus
);
  typedef enum logic [2:0] {IDLE = 3'd0, WR_ADDR = 3'd1, WR_CTRL = 3'd2, BUSY = 3'd3, ACK = 3'd4} state_t;
  state_t state, stateNxt;

  logic        ctrlEn, ctrlRepeat, ctrlIrqEn;
  logic        pending, front, stTimeout, stOverrun, stDone;
  logic [31:0] period, bufA, bufB, frameCount, periodCnt, busyCnt, startWord;
  logic [21:0] cfg;
  logic        tickLatch, ackTimeout;

  logic        tickNow, flipFront, frontNxt, irqSeen, busyExpired, timeoutHit, overrunSet, swapWr;
  logic        npWriteNxt;
  logic [3:0]  npAddrNxt;
  logic [31:0] npDataNxt;

  // PERIOD of 0 or 1 ticks every clock; >= keeps the timer sane if PERIOD shrinks below the count
  assign tickNow     = ctrlEn && ((period <= 32'd1) || (periodCnt >= period - 32'd1));
  assign irqSeen     = (busyCnt != 32'd0) && bus.iNP_IRQ;
  assign busyExpired = busyCnt >= pTIMEOUT - 32'd1;
  assign timeoutHit  = (state == BUSY) && busyExpired && !irqSeen;
  assign overrunSet  = tickNow && tickLatch && (state != IDLE);
  assign swapWr      = bus.iCSR_WRITE && (bus.iCSR_ADDRESS == 3'd6);
  assign frontNxt    = front ^ flipFront;

  always_ff @(posedge iCLOCK or negedge iRESET) begin
    if (!iRESET) state <= IDLE;
    else         state <= stateNxt;
  end

  always_comb begin
    stateNxt  = state;
    flipFront = 1'b0;
    case (state)
      IDLE: if (tickLatch) begin
        if (pending) begin
          flipFront = 1'b1;
          stateNxt  = WR_ADDR;
        end else if (ctrlRepeat) begin
          stateNxt  = WR_ADDR;
        end
      end
      WR_ADDR: stateNxt = WR_CTRL;
      WR_CTRL: stateNxt = BUSY;
      BUSY:    if (irqSeen || busyExpired) stateNxt = ACK;
      ACK:     stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // Outputs are computed for the state being entered, so data is frozen at state entry
  always_comb begin
    npWriteNxt = 1'b0;
    npAddrNxt  = 4'd0;
    npDataNxt  = 32'd0;
    case (stateNxt)
      WR_ADDR: begin
        npWriteNxt = 1'b1;
        npAddrNxt  = 4'd8;
        npDataNxt  = frontNxt ? bufB : bufA;
      end
      WR_CTRL: begin
        npWriteNxt = 1'b1;
        npAddrNxt  = 4'd1;
        npDataNxt  = {10'b0, cfg[21], 1'b1, cfg[19:0]};
      end
      ACK: begin
        npWriteNxt = 1'b1;
        npAddrNxt  = 4'd1;
        npDataNxt  = {startWord[31:21], 1'b0, startWord[19:0]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge iCLOCK or negedge iRESET) begin
    if (!iRESET) begin
      bus.oNP_WRITE      <= 1'b0;
      bus.oNP_ADDRESS    <= 4'd0;
      bus.oNP_WRITE_DATA <= 32'd0;
      startWord          <= 32'd0;
    end else begin
      bus.oNP_WRITE      <= npWriteNxt;
      bus.oNP_ADDRESS    <= npAddrNxt;
      bus.oNP_WRITE_DATA <= npDataNxt;
      if (stateNxt == WR_CTRL) startWord <= npDataNxt;
    end
  end

  always_ff @(posedge iCLOCK or negedge iRESET) begin
    if (!iRESET) begin
      periodCnt  <= 32'd0;
      tickLatch  <= 1'b0;
      busyCnt    <= 32'd0;
      ackTimeout <= 1'b0;
    end else begin
      if (!ctrlEn) begin
        periodCnt <= 32'd0;
        tickLatch <= 1'b0;
      end else begin
        periodCnt <= tickNow ? 32'd0 : periodCnt + 32'd1;
        if (tickNow)              tickLatch <= 1'b1;
        else if (state == IDLE)   tickLatch <= 1'b0;
      end
      busyCnt <= (state == BUSY) ? busyCnt + 32'd1 : 32'd0;
      if (state == BUSY) ackTimeout <= timeoutHit;
    end
  end

  // Later assignments win, so hardware set events dominate CPU clears in the same cycle
  always_ff @(posedge iCLOCK or negedge iRESET) begin
    if (!iRESET) begin
      {ctrlIrqEn, ctrlRepeat, ctrlEn} <= 3'b000;
      {pending, front, stTimeout, stOverrun, stDone} <= 5'b0;
      period     <= pPERIOD_RST;
      bufA       <= 32'd0;
      bufB       <= 32'd0;
      cfg        <= 22'd0;
      frameCount <= 32'd0;
    end else begin
      if (bus.iCSR_WRITE) begin
        case (bus.iCSR_ADDRESS)
          3'd0: {ctrlIrqEn, ctrlRepeat, ctrlEn} <= bus.iCSR_WRITE_DATA[2:0];
          3'd1: begin
            if (bus.iCSR_WRITE_DATA[3]) stTimeout <= 1'b0;
            if (bus.iCSR_WRITE_DATA[4]) stOverrun <= 1'b0;
            if (bus.iCSR_WRITE_DATA[5]) stDone    <= 1'b0;
          end
          3'd2: period     <= bus.iCSR_WRITE_DATA;
          3'd3: bufA       <= bus.iCSR_WRITE_DATA;
          3'd4: bufB       <= bus.iCSR_WRITE_DATA;
          3'd5: cfg        <= {bus.iCSR_WRITE_DATA[21], 1'b0, bus.iCSR_WRITE_DATA[19:0]};
          3'd7: frameCount <= 32'd0;
          default: ;
        endcase
      end
      if (swapWr)         pending <= 1'b1;
      else if (flipFront) pending <= 1'b0;
      front <= frontNxt;
      if (overrunSet) stOverrun <= 1'b1;
      if (timeoutHit) begin
        stTimeout <= 1'b1;
        ctrlEn    <= 1'b0;
      end
      if ((state == ACK) && !ackTimeout) begin
        frameCount <= frameCount + 32'd1;
        stDone     <= 1'b1;
      end
    end
  end

  always_ff @(posedge iCLOCK or negedge iRESET) begin
    if (!iRESET) begin
      bus.oCSR_READ_DATA <= 32'd0;
      bus.oIRQ           <= 1'b0;
    end else begin
      if (bus.iCSR_READ) begin
        case (bus.iCSR_ADDRESS)
          3'd0: bus.oCSR_READ_DATA <= {29'd0, ctrlIrqEn, ctrlRepeat, ctrlEn};
          3'd1: bus.oCSR_READ_DATA <= {26'd0, stDone, stOverrun, stTimeout, front, pending, state != IDLE};
          3'd2: bus.oCSR_READ_DATA <= period;
          3'd3: bus.oCSR_READ_DATA <= bufA;
          3'd4: bus.oCSR_READ_DATA <= bufB;
          3'd5: bus.oCSR_READ_DATA <= {10'd0, cfg};
          3'd6: bus.oCSR_READ_DATA <= 32'd0;
          3'd7: bus.oCSR_READ_DATA <= frameCount;
          default: bus.oCSR_READ_DATA <= 32'd0;
        endcase
      end
      bus.oIRQ <= ctrlIrqEn & (stDone | stTimeout);
    end
  end
endmodule

// File: tb/tb_neopixel_frame_sched.sv
// Directed bench: NEOPIXEL write scoreboard fed by a frame-level model, plus a reactive NEOPIXEL IRQ responder.
module tb_neopixel_frame_sched;
  localparam logic [31:0] TIMEOUT = 32'd1000;

  logic iCLOCK, iRESET;
  neopixel_frame_sched_if bus ();

  neopixel_frame_sched #(.pTIMEOUT(TIMEOUT)) dut (
    .iCLOCK (iCLOCK),
    .iRESET (iRESET),
    .bus    (bus)
  );

  initial iCLOCK = 1'b0;
  always #5 iCLOCK = ~iCLOCK;

  typedef struct packed {logic [3:0] a; logic [31:0] d;} npw_t;

  int          checks = 0, failures = 0;
  int          cyc = 0, wrCount = 0, npDelay = -1, npCnt = -1;
  int          wrCyc[$];
  logic [31:0] wrDat[$];
  npw_t        expQ[$];

  // Frame-level model of the programmer-visible registers
  logic [31:0] mBufA, mBufB;
  logic [21:0] mCfg;
  logic        mFront;
  int          mFrames;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  always @(posedge iCLOCK) cyc <= cyc + 1;

  // Compare process and NEOPIXEL model: each start write arms the IRQ after npDelay clocks, ACK clears it
  always @(negedge iCLOCK) begin
    npw_t e;
    if (!iRESET) begin
      bus.iNP_IRQ = 1'b0;
      npCnt = -1;
    end else begin
      if (npCnt > 0) npCnt--;
      if (npCnt == 0) begin
        bus.iNP_IRQ = 1'b1;
        npCnt = -1;
      end
      if (bus.oNP_WRITE) begin
        wrCyc.push_back(cyc);
        wrDat.push_back(bus.oNP_WRITE_DATA);
        wrCount++;
        if (expQ.size() == 0) begin
          chk("np_write_spurious", {63'd0, bus.oNP_WRITE}, 64'd0);
        end else begin
          e = expQ.pop_front();
          chk("np_write", {28'd0, bus.oNP_ADDRESS, bus.oNP_WRITE_DATA}, {28'd0, e.a, e.d});
        end
        if (bus.oNP_ADDRESS == 4'd1) begin
          bus.iNP_IRQ = 1'b0;
          npCnt = bus.oNP_WRITE_DATA[20] ? npDelay : -1;
        end
      end
    end
  end

  task automatic pushFrame(input logic useB, input logic withAck);
    logic [31:0] start;
    start = {10'b0, mCfg[21], 1'b1, mCfg[19:0]};
    expQ.push_back({4'd8, useB ? mBufB : mBufA});
    expQ.push_back({4'd1, start});
    if (withAck) expQ.push_back({4'd1, start & ~32'h0010_0000});
  endtask

  task automatic csrWr(input logic [2:0] a, input logic [31:0] d);
    @(negedge iCLOCK);
    bus.iCSR_ADDRESS = a; bus.iCSR_WRITE_DATA = d; bus.iCSR_WRITE = 1'b1;
    @(negedge iCLOCK);
    bus.iCSR_WRITE = 1'b0;
  endtask

  task automatic csrRd(input logic [2:0] a, output logic [31:0] d);
    @(negedge iCLOCK);
    bus.iCSR_ADDRESS = a; bus.iCSR_READ = 1'b1;
    @(negedge iCLOCK);
    bus.iCSR_READ = 1'b0;
    d = bus.oCSR_READ_DATA;
  endtask

  task automatic rdChk(input string nm, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] v;
    csrRd(a, v);
    chk(nm, {32'd0, v}, {32'd0, exp});
  endtask

  task automatic waitWrites(input int target, input int budget, input string nm);
    int n = 0;
    while (wrCount < target && n < budget) begin
      @(negedge iCLOCK);
      n++;
    end
    chk(nm, wrCount, target);
  endtask

  initial begin
    int tEn, base;
    iRESET = 1'b0;
    bus.iCSR_ADDRESS = 3'd0; bus.iCSR_READ = 1'b0; bus.iCSR_WRITE = 1'b0; bus.iCSR_WRITE_DATA = 32'd0;
    mBufA = 32'd0; mBufB = 32'd0; mCfg = 22'd0; mFront = 1'b0; mFrames = 0;
    repeat (3) @(negedge iCLOCK);
    iRESET = 1'b1;

    // Reset state
    rdChk("rst_ctrl", 3'd0, 32'd0);
    rdChk("rst_status", 3'd1, 32'd0);
    rdChk("rst_period", 3'd2, 32'd1_666_666);
    rdChk("rst_frame_count", 3'd7, 32'd0);
    chk("rst_oirq", {63'd0, bus.oIRQ}, 64'd0);

    // First frame: PERIOD=100, buffer A, REPEAT on
    csrWr(3'd2, 32'd100);
    csrWr(3'd3, 32'h1000); mBufA = 32'h1000;
    csrWr(3'd5, 32'h0000_0017); mCfg = 22'h17;
    npDelay = 50;
    pushFrame(mFront, 1'b1);
    csrWr(3'd0, 32'd7);
    tEn = cyc;
    waitWrites(3, 400, "frame1_writes");
    csrWr(3'd0, 32'd5);
    mFrames++;
    chk("frame1_latency", wrCyc[0] - tEn, 101);
    chk("frame1_start_word", {32'd0, wrDat[1]}, 64'h0010_0017);
    chk("frame1_ack_word", {32'd0, wrDat[2]}, 64'h0000_0017);
    rdChk("frame1_count", 3'd7, mFrames);
    rdChk("frame1_status", 3'd1, 32'h20);
    chk("frame1_oirq", {63'd0, bus.oIRQ}, 64'd1);
    csrWr(3'd1, 32'h20);
    @(negedge iCLOCK);
    chk("done_w1c_oirq", {63'd0, bus.oIRQ}, 64'd0);

    // SWAP to buffer B, then back to A
    csrWr(3'd4, 32'h2000); mBufB = 32'h2000;
    mFront = ~mFront;
    pushFrame(mFront, 1'b1);
    csrWr(3'd6, 32'd0);
    rdChk("swap_pending", 3'd1, 32'h02);
    waitWrites(6, 300, "swap1_writes");
    mFrames++;
    rdChk("swap1_status", 3'd1, 32'h24);
    rdChk("swap1_count", 3'd7, mFrames);
    mFront = ~mFront;
    pushFrame(mFront, 1'b1);
    csrWr(3'd6, 32'd0);
    waitWrites(9, 300, "swap2_writes");
    mFrames++;
    rdChk("swap2_status", 3'd1, 32'h20);

    // No REPEAT, no SWAP: three periods with no NEOPIXEL traffic
    repeat (300) @(negedge iCLOCK);
    chk("idle_no_writes", wrCount, 9);
    rdChk("idle_count", 3'd7, mFrames);

    // IRQ held off 250 clocks: overrun, exactly one back-to-back frame
    npDelay = 250;
    pushFrame(mFront, 1'b1);
    pushFrame(mFront, 1'b1);
    csrWr(3'd0, 32'd7);
    waitWrites(12, 500, "overrun_frame_a");
    npDelay = 20;
    csrWr(3'd0, 32'd5);
    waitWrites(15, 200, "overrun_frame_b");
    mFrames += 2;
    chk("overrun_back_to_back", wrCyc[12] - wrCyc[11], 2);
    rdChk("overrun_status", 3'd1, 32'h30);
    repeat (300) @(negedge iCLOCK);
    chk("overrun_single_extra", wrCount, 15);
    rdChk("overrun_count", 3'd7, mFrames);
    csrWr(3'd1, 32'h38);

    // Hung frame: IRQ never arrives
    npDelay = -1;
    mFront = ~mFront;
    pushFrame(mFront, 1'b1);
    csrWr(3'd6, 32'd0);
    waitWrites(18, 1400, "timeout_writes");
    chk("timeout_window", {63'd0, (wrCyc[17] - wrCyc[16] >= int'(TIMEOUT)) && (wrCyc[17] - wrCyc[16] <= int'(TIMEOUT) + 2)}, 64'd1);
    rdChk("timeout_status", 3'd1, 32'h1C);
    rdChk("timeout_ctrl", 3'd0, 32'd4);
    rdChk("timeout_count", 3'd7, mFrames);
    chk("timeout_oirq", {63'd0, bus.oIRQ}, 64'd1);
    csrWr(3'd1, 32'h18);
    @(negedge iCLOCK);
    chk("timeout_w1c_oirq", {63'd0, bus.oIRQ}, 64'd0);
    rdChk("timeout_cleared", 3'd1, 32'h04);

    // Reset while BUSY
    pushFrame(mFront, 1'b0);
    csrWr(3'd0, 32'd3);
    waitWrites(20, 300, "reset_frame_start");
    base = wrCount;
    repeat (10) @(negedge iCLOCK);
    #3 iRESET = 1'b0;
    #1 chk("async_reset_outputs",
           {18'd0, bus.oNP_WRITE, bus.oNP_ADDRESS, bus.oIRQ, bus.oNP_WRITE_DATA[7:0], bus.oCSR_READ_DATA},
           64'd0);
    chk("async_reset_np_data", {32'd0, bus.oNP_WRITE_DATA}, 64'd0);
    expQ.delete();
    mFront = 1'b0; mBufA = 32'd0; mBufB = 32'd0; mCfg = 22'd0; mFrames = 0;
    repeat (2) @(negedge iCLOCK);
    iRESET = 1'b1;
    repeat (300) @(negedge iCLOCK);
    chk("post_reset_no_writes", wrCount, base);
    rdChk("post_reset_ctrl", 3'd0, 32'd0);
    rdChk("post_reset_status", 3'd1, 32'd0);
    rdChk("post_reset_period", 3'd2, 32'd1_666_666);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog cycles=%0d limit=40000", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end
endmodule
